// File: rtl/cpu_pkg.sv
// Shared CPU definitions: architectural widths, canonical NOP and the
// fetch FIFO entry layout (instruction word plus its byte address).
package cpu_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned INST_BYTES = 4;

   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] word;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush. Head data is read combinationally from the
// storage array; push while full is only honoured together with a pop.
// Ports: clock, reset (sync, active-high), flush (drop contents, keep storage),
//        push/push_data (write), pop (advance head), pop_data (head word),
//        valid (not empty), full (DEPTH entries held).
module sync_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             valid,
   output logic             full
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             push_ok;
   logic             pop_ok;

   assign valid    = (count != '0);
   assign full     = (count == CW'(DEPTH));
   assign pop_ok   = pop & valid;
   assign push_ok  = push & (~full | pop_ok);
   assign pop_data = mem[rd_ptr];

   // Storage: cleared on reset only; a flush leaves stale words behind.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else if (push_ok && !flush) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch stage: drives the ROM address from fetch_pc, captures the
// same-cycle ROM word with its PC into a small FIFO and hands it to decode
// over valid/ready. A redirect flushes the FIFO and restarts at the target.
// Ports: clock, reset (sync, active-high), fetch_enable, rom_address/rom_rdata
//        (async ROM), redirect_valid/redirect_pc (from execute),
//        inst_valid/inst_ready/inst_data/inst_pc (to decode).
module fetch_prefetch
   import cpu_pkg::*;
#(
   parameter int unsigned     WIDTH    = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             fetch_enable,
   output logic [WIDTH-1:0] rom_address,
   input  logic [WIDTH-1:0] rom_rdata,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic             inst_valid,
   input  logic             inst_ready,
   output logic [WIDTH-1:0] inst_data,
   output logic [WIDTH-1:0] inst_pc
);

   localparam int unsigned EW = 2 * WIDTH;

   logic [WIDTH-1:0] fetch_pc;
   logic             deq;
   logic             enq;
   logic             full;
   fetch_entry_t     push_entry;
   fetch_entry_t     head_entry;
   logic [EW-1:0]    head_raw;

   assign rom_address = fetch_pc;

   // A full FIFO still takes a word when decode drains the head this cycle.
   assign deq = inst_valid & inst_ready;
   assign enq = fetch_enable & ~redirect_valid & (~full | deq);

   assign push_entry = '{word: XLEN'(rom_rdata), pc: XLEN'(fetch_pc)};
   assign head_entry = fetch_entry_t'(head_raw);
   assign inst_data  = WIDTH'(head_entry.word);
   assign inst_pc    = WIDTH'(head_entry.pc);

   // Fetch PC: reset beats redirect; redirect targets are forced word aligned.
   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
      end else if (redirect_valid) begin
         fetch_pc <= {redirect_pc[WIDTH-1:2], 2'b00};
      end else if (enq) begin
         fetch_pc <= fetch_pc + WIDTH'(INST_BYTES);
      end
   end

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (redirect_valid),
      .push      (enq),
      .push_data (EW'(push_entry)),
      .pop       (deq),
      .pop_data  (head_raw),
      .valid     (inst_valid),
      .full      (full)
   );

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: directed vector table for the fetch corner cases,
// then randomized traffic checked against a queue-based reference model.
module tb_fetch_prefetch;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clock = 1'b0;
   logic        reset;
   logic        fetch_enable;
   logic [31:0] rom_address;
   logic [31:0] rom_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;

   always #5 clock = ~clock;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return 32'h1000_0000 + (a >> 2);
   endfunction

   assign rom_rdata = rom_word(rom_address);

   fetch_prefetch #(.WIDTH(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clock          (clock),
      .reset          (reset),
      .fetch_enable   (fetch_enable),
      .rom_address    (rom_address),
      .rom_rdata      (rom_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of delivered-to-be instructions and the next PC.
   typedef struct packed { logic [31:0] word; logic [31:0] pc; } ent_t;
   ent_t        mq[$];
   logic [31:0] m_pc;
   bit          m_live = 0;

   task automatic model_check();
      if (!m_live) return;
      check("model_valid", 32'(inst_valid), 32'(mq.size() != 0));
      check("model_rom_address", rom_address, m_pc);
      if (mq.size() != 0) begin
         check("model_inst_data", inst_data, mq[0].word);
         check("model_inst_pc", inst_pc, mq[0].pc);
      end
   endtask

   task automatic model_step();
      bit deq_m;
      bit full_m;
      if (reset) begin
         mq.delete();
         m_pc   = RESET_PC;
         m_live = 1;
         return;
      end
      if (!m_live) return;
      deq_m  = (mq.size() != 0) && inst_ready;
      full_m = (mq.size() == DEPTH);
      if (redirect_valid) begin
         mq.delete();
         m_pc = redirect_pc & ~32'h3;
      end else begin
         if (deq_m) void'(mq.pop_front());
         if (fetch_enable && (!full_m || deq_m)) begin
            mq.push_back('{word: rom_word(m_pc), pc: m_pc});
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   // Directed vectors: inputs for a cycle and the outputs expected in that
   // same cycle (before the edge that consumes the inputs).
   typedef struct {
      logic rst, fe, rv; logic [31:0] rpc; logic rdy;
      logic chk, ev; logic [31:0] erom, epc, edata; logic hd;
   } vec_t;

   function automatic vec_t mk(input logic rst, fe, rv, input logic [31:0] rpc,
                               input logic rdy, chk, ev, input logic [31:0] erom,
                               epc, edata, input logic hd);
      vec_t v;
      v.rst = rst; v.fe = fe; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
      v.chk = chk; v.ev = ev; v.erom = erom; v.epc = epc; v.edata = edata; v.hd = hd;
      return v;
   endfunction

   vec_t tbl[21];

   task automatic drive(input logic rst, fe, rv, input logic [31:0] rpc, input logic rdy);
      reset = rst; fetch_enable = fe; redirect_valid = rv;
      redirect_pc = rpc; inst_ready = rdy;
   endtask

   initial begin
      //              rst fe rv rpc           rdy chk ev erom          epc           edata         hd
      tbl[0]  = mk(1, 1, 0, 32'h0,        1,  0, 0, 32'h0,        32'h0,        32'h0,        0);
      tbl[1]  = mk(0, 1, 0, 32'h0,        1,  1, 0, 32'h0,        32'h0,        32'h0,        1);
      tbl[2]  = mk(0, 1, 0, 32'h0,        1,  1, 1, 32'h4,        32'h0,        32'h1000_0000, 1);
      tbl[3]  = mk(0, 1, 0, 32'h0,        0,  1, 1, 32'h8,        32'h4,        32'h1000_0001, 1);
      tbl[4]  = mk(0, 1, 0, 32'h0,        0,  1, 1, 32'hC,        32'h4,        32'h1000_0001, 1);
      tbl[5]  = mk(0, 1, 0, 32'h0,        0,  1, 1, 32'h10,       32'h4,        32'h1000_0001, 1);
      tbl[6]  = mk(0, 1, 0, 32'h0,        0,  1, 1, 32'h14,       32'h4,        32'h1000_0001, 1);
      tbl[7]  = mk(0, 1, 0, 32'h0,        0,  1, 1, 32'h14,       32'h4,        32'h1000_0001, 1);
      tbl[8]  = mk(0, 1, 0, 32'h0,        1,  1, 1, 32'h14,       32'h4,        32'h1000_0001, 1);
      tbl[9]  = mk(0, 1, 0, 32'h0,        0,  1, 1, 32'h18,       32'h8,        32'h1000_0002, 1);
      tbl[10] = mk(0, 1, 0, 32'h0,        1,  1, 1, 32'h18,       32'h8,        32'h1000_0002, 1);
      tbl[11] = mk(0, 0, 0, 32'h0,        1,  1, 1, 32'h1C,       32'hC,        32'h1000_0003, 1);
      tbl[12] = mk(0, 1, 1, 32'h102,      0,  1, 1, 32'h1C,       32'h10,       32'h1000_0004, 1);
      tbl[13] = mk(0, 1, 0, 32'h0,        1,  1, 0, 32'h100,      32'h0,        32'h0,        0);
      tbl[14] = mk(0, 1, 1, 32'hFFFF_FFFC, 1, 1, 1, 32'h104,      32'h100,      32'h1000_0040, 1);
      tbl[15] = mk(0, 1, 0, 32'h0,        1,  1, 0, 32'hFFFF_FFFC, 32'h0,       32'h0,        0);
      tbl[16] = mk(0, 1, 0, 32'h0,        1,  1, 1, 32'h0,        32'hFFFF_FFFC, 32'h4FFF_FFFF, 1);
      tbl[17] = mk(0, 0, 0, 32'h0,        1,  1, 1, 32'h4,        32'h0,        32'h1000_0000, 1);
      tbl[18] = mk(1, 0, 1, 32'h200,      0,  1, 0, 32'h4,        32'h0,        32'h0,        0);
      tbl[19] = mk(0, 1, 0, 32'h0,        1,  1, 0, 32'h0,        32'h0,        32'h0,        1);
      tbl[20] = mk(0, 1, 0, 32'h0,        1,  1, 1, 32'h4,        32'h0,        32'h1000_0000, 1);

      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

      for (int i = 0; i < 21; i++) begin
         @(negedge clock);
         drive(tbl[i].rst, tbl[i].fe, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
         #1;
         if (tbl[i].chk) begin
            check($sformatf("vec%0d_valid", i), 32'(inst_valid), 32'(tbl[i].ev));
            check($sformatf("vec%0d_rom_address", i), rom_address, tbl[i].erom);
            if (tbl[i].hd) begin
               check($sformatf("vec%0d_inst_pc", i), inst_pc, tbl[i].epc);
               check($sformatf("vec%0d_inst_data", i), inst_data, tbl[i].edata);
            end
         end
         model_check();
         @(posedge clock);
         model_step();
      end

      // Hold-stable corner: stall with a valid head for several cycles.
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
         #1;
         check("stall_head_pc", inst_pc, 32'h4);
         model_check();
         @(posedge clock);
         model_step();
      end

      // Randomized traffic against the reference model.
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] rpc;
         rpc = $urandom();
         if ($urandom_range(0, 3) == 0) rpc = {24'hFFFF_FF, rpc[7:0]};
         @(negedge clock);
         drive(1'($urandom_range(0, 99) == 0),
               1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 11) == 0),
               rpc,
               1'($urandom_range(0, 1)));
         #1;
         model_check();
         @(posedge clock);
         model_step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_prefetch.md
Name: fetch_prefetch

Overview:
- Instruction fetch stage between the asynchronous program ROM (32-bit words, byte address, +4 per word) and the RV32 decode stage.
- Holds the fetch PC and drives the ROM address every cycle.
- Captures returned words into a small FIFO with their PCs and presents them to decode over a valid/ready handshake.
- Handles control-flow redirects from execute by flushing the FIFO and restarting at the target.

Parameters:
- WIDTH, 32, instruction, address and PC width in bits.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset; word aligned.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- fetch_enable  input  1  permits new ROM fetches while high; held low, the FIFO still drains.
- rom_address  output  WIDTH  byte address to the ROM; equals fetch_pc.
- rom_rdata  input  WIDTH  ROM word for rom_address, valid in the same cycle.
- redirect_valid  input  1  execute requests a PC change this cycle.
- redirect_pc  input  WIDTH  target byte address.
- inst_valid  output  1  FIFO head holds a valid instruction.
- inst_ready  input  1  decode accepts the head this cycle.
- inst_data  output  WIDTH  instruction word at the FIFO head.
- inst_pc  output  WIDTH  byte address of inst_data.

Behaviour:
- State:
  - fetch_pc register.
  - DEPTH-entry storage of {word, pc}.
  - Read and write pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
  - count of log2(DEPTH)+1 bits.
- Reset, in the cycle reset is sampled high:
  - fetch_pc = RESET_PC, so rom_address = RESET_PC.
  - Pointers = 0, count = 0, inst_valid = 0.
  - All storage cleared, so inst_data = 0 and inst_pc = 0.
  - Reset overrides redirect and all handshakes.
- Handshake terms:
  - deq = inst_valid & inst_ready.
  - enq = fetch_enable & ~redirect_valid & (count < DEPTH | deq).
  - A full FIFO accepts a new word in the same cycle as a dequeue.
- Enqueue:
  - Write {rom_rdata, fetch_pc} at the write pointer.
  - fetch_pc <= fetch_pc + 4, wrapping modulo 2^WIDTH; 32'hFFFF_FFFC becomes 0.
  - ROM-to-FIFO latency is 0: the word is written at the edge ending the cycle its address is driven.
  - FIFO-to-decode latency is 1 cycle: the word is visible on inst_data the cycle after the fetch.
- Dequeue: advance the read pointer.
- count update:
  - +1 on enq only, -1 on deq only, unchanged on both.
  - Never exceeds DEPTH; never underflows.
- inst_valid = (count != 0). inst_data and inst_pc are driven combinationally from the head entry.
- inst_valid, inst_data and inst_pc hold stable while inst_valid & ~inst_ready.
- Redirect (redirect_valid = 1):
  - Flush: pointers = 0, count = 0. Any deq in the same cycle is still taken as accepted by decode.
  - fetch_pc <= {redirect_pc[WIDTH-1:2], 2'b00}; misaligned low bits are silently cleared.
  - No enqueue that cycle; fetching at the target starts the next cycle.
  - inst_valid = 0 in the cycle after the redirect; the first target instruction is valid 2 cycles after the redirect cycle.
  - Back-to-back redirects: the last one wins.
- fetch_enable = 0: fetch_pc holds and the FIFO drains normally. A redirect is still taken.
- No FSM beyond the FIFO occupancy; the count encodes EMPTY, PARTIAL and FULL.

Decomposition:
- Shared package (cpu_pkg):
  - XLEN = 32.
  - INST_BYTES = 4.
  - NOP encoding 32'h0000_0013.
  - The fetch_entry_t packed struct {word, pc}.
- One natural sub-module: sync_fifo, parameterised on width and depth, with a flush input. It is instantiated with width 2*WIDTH.
- PC logic stays in fetch_prefetch.

Test Plan:
- Reset release, ROM word i = 32'h1000_0000 + i, inst_ready = 1 → rom_address sequence 0, 4, 8 …; inst_data 32'h1000_0000 with inst_pc 0 valid the cycle after first fetch; one instruction per cycle thereafter.
- inst_ready = 0 for 10 cycles, then 1 → count saturates at 4, rom_address stops at 16, head held at pc 0; on release, pcs 0, 4, 8, 12, 16 delivered in order with no gaps or duplicates.
- While full, pulse inst_ready for 1 cycle → exactly one dequeue and one enqueue, count stays 4, fetch_pc advances by 4.
- redirect_valid with redirect_pc = 32'h0000_0102 while the FIFO holds 3 entries → next cycle inst_valid = 0 and rom_address = 32'h100; the following cycle inst_pc = 32'h100; stale entries never appear.
- Redirect to 32'hFFFF_FFFC, then two fetches → inst_pc FFFF_FFFC followed by 0000_0000.
- fetch_enable = 0 mid-stream, then reset asserted for 1 cycle mid-operation → FIFO drains while fetch_pc holds; after reset rom_address = RESET_PC, inst_valid = 0, and the earlier redirect target is discarded.
